uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL expose parameter Depth, default 8, number of byte entries; power of two, range 2 to 256.
REQ-002 The block SHALL expose parameter CountWidth, default log2(Depth)+1, width of the occupancy count.
REQ-003 The block SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port DataIn, input, 8, byte offered by the producer.
REQ-006 The block SHALL have port DataInValid, input, 1, producer asserts that DataIn is valid.
REQ-007 The block SHALL have port DataInReady, output, 1, queue accepts a byte this cycle.
REQ-008 The block SHALL have port DataOut, output, 8, head byte presented to the UART transmitter.
REQ-009 The block SHALL have port DataOutValid, output, 1, DataOut holds a valid head byte.
REQ-010 The block SHALL have port DataOutReady, input, 1, transmitter consumes the head byte this cycle.
REQ-011 The block SHALL have port Overflow, output, 1, sticky flag set by a push attempt while full.

Function
REQ-012 Push SHALL occur when DataInValid and DataInReady are both high; pop SHALL occur when DataOutValid and DataOutReady are both high.
REQ-013 DataInReady SHALL equal (count != Depth) and SHALL depend only on registered state, not on DataOutReady.
REQ-014 DataOutValid SHALL equal (count != 0); DataOut SHALL show the oldest stored byte (show-ahead), with no combinational path from DataIn.
REQ-015 A push into an empty queue SHALL raise DataOutValid, with DataOut equal to the pushed byte, exactly one cycle after the push edge.
REQ-016 Bytes SHALL leave in push order with no loss or duplication.
REQ-017 Simultaneous push and pop with 0 < count < Depth SHALL leave count unchanged and advance both pointers.
REQ-018 When full, a push attempt SHALL be refused even with a concurrent pop; the pop SHALL proceed and count SHALL drop by 1.
REQ-019 When empty, DataOutReady SHALL be ignored and count SHALL stay 0.
REQ-020 Read and write pointers SHALL be log2(Depth) bits and wrap from Depth-1 to 0 naturally.
REQ-021 Overflow SHALL set on the cycle after DataInValid is high with count == Depth, and hold until Reset.
REQ-022 While DataOutValid is high and DataOutReady is low, DataOut SHALL remain stable.

Reset
REQ-023 Reset SHALL clear count and both pointers and Overflow to 0 on the next rising Clock edge.
REQ-024 After Reset: DataOutValid=0, DataInReady=1, DataOut=8'h00; storage contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all queued bytes; a push or pop coinciding with Reset SHALL have no effect.

Configuration
REQ-026 Macro UART_TX_QUEUE_STATUS_EN defined: the block SHALL add output Count, CountWidth bits, registered occupancy 0..Depth, reset 0.
REQ-027 Macro UART_TX_QUEUE_STATUS_EN undefined: port Count SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then push 8'hA5 with DataOutReady=0 -> DataOutValid=1 and DataOut=8'hA5 next cycle; DataInReady stays 1.
REQ-029 Push 8'h01..8'h08 back-to-back (Depth=8) with DataOutReady=0 -> DataInReady=0 after the 8th push; 9th attempt -> Overflow=1 next cycle, and the byte is not stored.
REQ-030 Full queue with DataInValid=1 and DataOutReady=1 for one cycle -> 8'h01 popped, push refused, count=7 (Count=7 if enabled), DataOut=8'h02.
REQ-031 Count=3, continuous push/pop for 20 cycles with an incrementing pattern -> count stays 3, pointers wrap, output order is exact.
REQ-032 Count=5 with Overflow=1, assert Reset for 1 cycle during a push -> DataOutValid=0, DataInReady=1, Overflow=0, Count=0.
REQ-033 Empty queue with DataOutReady=1 for 4 cycles -> DataOutValid stays 0 and count stays 0.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between a byte producer, the transmit queue and the UART transmitter.
// The queue takes the slave modport. The master modport is the environment around it,
// which drives DataIn and DataInValid on the producer side and DataOutReady on the
// transmitter side.
interface uart_tx_queue_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady,
        input  DataOut,
        input  DataOutValid,
        output DataOutReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady,
        output DataOut,
        output DataOutValid,
        input  DataOutReady
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Show-ahead byte queue that sits between a producer and a UART transmitter.
// Overflow is a sticky flag. It is set by any push attempt made while the queue is full.
// Optional macro UART_TX_QUEUE_STATUS_EN adds a registered Count output that reports occupancy.
module uart_tx_queue #(
    parameter int Depth      = 8,
    parameter int CountWidth = $clog2(Depth) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    uart_tx_queue_if.slave        bus,
`ifdef UART_TX_QUEUE_STATUS_EN
    output logic                  Overflow,
    output logic [CountWidth-1:0] Count
`else
    output logic                  Overflow
`endif
);
    localparam int PtrWidth = $clog2(Depth);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [7:0]            mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  push;
    logic                  pop;

    // Ready and valid come only from the registered count. A pop therefore
    // cannot make room for a push in the same cycle.
    assign bus.DataInReady  = (count != FullCount);
    assign bus.DataOutValid = (count != '0);
    assign push             = bus.DataInValid && bus.DataInReady;
    assign pop              = bus.DataOutValid && bus.DataOutReady;

    // The head byte is read straight from storage. It is forced to zero while the
    // queue is empty, so a reset shows 8'h00 without the storage having to be cleared.
    assign bus.DataOut = bus.DataOutValid ? mem[rd_ptr] : 8'h00;

`ifdef UART_TX_QUEUE_STATUS_EN
    assign Count = count;
`else
`endif

    // The storage array has no reset. A write is blocked while Reset is high.
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            mem[wr_ptr] <= bus.DataIn;
        end
    end

    // The pointers wrap by natural overflow. The occupancy count holds when a push
    // and a pop happen in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Any push attempt against a full queue sets the overflow flag. Only Reset clears it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (bus.DataInValid && (count == FullCount)) begin
            Overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with Depth=8.
// Each scenario task drives its own stimulus and checks its own expected values.
module tb_uart_tx_queue;
    logic Clock;
    logic Reset;
    logic Overflow;
`ifdef UART_TX_QUEUE_STATUS_EN
    logic [3:0] Count;
`endif

    int vectors;
    int miscompares;

    uart_tx_queue_if bus ();

    uart_tx_queue #(.Depth(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .bus      (bus.slave),
`ifdef UART_TX_QUEUE_STATUS_EN
        .Overflow (Overflow),
        .Count    (Count)
`else
        .Overflow (Overflow)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.DataInValid  = 1'b0;
        bus.DataOutReady = 1'b0;
        bus.DataIn       = 8'h00;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.DataOutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid got=%b exp=0", bus.DataOutValid);
        end
        vectors++;
        if (bus.DataInReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got=%b exp=1", bus.DataInReady);
        end
        vectors++;
        if (bus.DataOut !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_data got=%h exp=00", bus.DataOut);
        end
        vectors++;
        if (Overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overflow got=%b exp=0", Overflow);
        end
`ifdef UART_TX_QUEUE_STATUS_EN
        vectors++;
        if (Count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count got=%0d exp=0", Count);
        end
`endif
    endtask

    task automatic test_single_push();
        do_reset();
        bus.DataIn      = 8'hA5;
        bus.DataInValid = 1'b1;
        step();
        bus.DataInValid = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL single_head got=%b/%h exp=1/a5", bus.DataOutValid, bus.DataOut);
        end
        vectors++;
        if (bus.DataInReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_ready got=%b exp=1", bus.DataInReady);
        end
        bus.DataOutReady = 1'b1;
        step();
        bus.DataOutReady = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b0 || bus.DataOut !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL single_drain got=%b/%h exp=0/00", bus.DataOutValid, bus.DataOut);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.DataIn      = 8'(i);
            bus.DataInValid = 1'b1;
            step();
            vectors++;
            if (bus.DataInReady !== (i < 8)) begin
                miscompares++;
                $display("[TB] FAIL fill_ready[%0d] got=%b exp=%b", i, bus.DataInReady, (i < 8));
            end
            vectors++;
            if (bus.DataOut !== 8'h01) begin
                miscompares++;
                $display("[TB] FAIL fill_head[%0d] got=%h exp=01", i, bus.DataOut);
            end
        end
        vectors++;
        if (Overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_no_overflow got=%b exp=0", Overflow);
        end
        bus.DataIn = 8'h09;
        step();
        bus.DataInValid = 1'b0;
        vectors++;
        if (Overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_set got=%b exp=1", Overflow);
        end
        vectors++;
        if (bus.DataInReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_ready got=%b exp=0", bus.DataInReady);
        end
    endtask

    // This scenario continues from the full queue left by test_fill_overflow.
    task automatic test_full_push_pop();
        bus.DataIn       = 8'h0A;
        bus.DataInValid  = 1'b1;
        bus.DataOutReady = 1'b1;
        step();
        bus.DataInValid  = 1'b0;
        bus.DataOutReady = 1'b0;
        vectors++;
        if (bus.DataOut !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL fullpp_head got=%h exp=02", bus.DataOut);
        end
        vectors++;
        if (bus.DataInReady !== 1'b1 || Overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fullpp_flags got=%b/%b exp=1/1", bus.DataInReady, Overflow);
        end
`ifdef UART_TX_QUEUE_STATUS_EN
        vectors++;
        if (Count !== 4'd7) begin
            miscompares++;
            $display("[TB] FAIL fullpp_count got=%0d exp=7", Count);
        end
`endif
        bus.DataOutReady = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            vectors++;
            if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL drain_order[%0d] got=%b/%h exp=1/%h", i, bus.DataOutValid, bus.DataOut, 8'(i));
            end
            step();
        end
        bus.DataOutReady = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_empty got=%b exp=0", bus.DataOutValid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.DataIn      = 8'(8'h10 + i);
            bus.DataInValid = 1'b1;
            step();
        end
        bus.DataOutReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 8'(8'h10 + i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_order[%0d] got=%b/%h exp=1/%h", i, bus.DataOutValid, bus.DataOut, 8'(8'h10 + i));
            end
            bus.DataIn = 8'(8'h13 + i);
            step();
        end
        bus.DataInValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 8'(8'h24 + i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_tail[%0d] got=%b/%h exp=1/%h", i, bus.DataOutValid, bus.DataOut, 8'(8'h24 + i));
            end
            step();
        end
        bus.DataOutReady = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_empty got=%b exp=0", bus.DataOutValid);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.DataInValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.DataIn = 8'(8'h40 + i);
            step();
        end
        bus.DataInValid  = 1'b0;
        bus.DataOutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        bus.DataOutReady = 1'b0;
        vectors++;
        if (Overflow !== 1'b1 || bus.DataOut !== 8'h43) begin
            miscompares++;
            $display("[TB] FAIL midop_setup got=%b/%h exp=1/43", Overflow, bus.DataOut);
        end
        bus.DataIn      = 8'h77;
        bus.DataInValid = 1'b1;
        Reset           = 1'b1;
        step();
        Reset           = 1'b0;
        bus.DataInValid = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b0 || bus.DataInReady !== 1'b1 || Overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_state got=%b/%b/%b exp=0/1/0", bus.DataOutValid, bus.DataInReady, Overflow);
        end
`ifdef UART_TX_QUEUE_STATUS_EN
        vectors++;
        if (Count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL midop_count got=%0d exp=0", Count);
        end
`endif
        step();
        vectors++;
        if (bus.DataOutValid !== 1'b0 || bus.DataOut !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midop_after got=%b/%h exp=0/00", bus.DataOutValid, bus.DataOut);
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        bus.DataOutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (bus.DataOutValid !== 1'b0 || bus.DataInReady !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL empty_pop[%0d] got=%b/%b exp=0/1", i, bus.DataOutValid, bus.DataInReady);
            end
        end
        bus.DataOutReady = 1'b0;
        bus.DataIn       = 8'h5C;
        bus.DataInValid  = 1'b1;
        step();
        bus.DataInValid  = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 8'h5C) begin
            miscompares++;
            $display("[TB] FAIL empty_push got=%b/%h exp=1/5c", bus.DataOutValid, bus.DataOut);
        end
        bus.DataOutReady = 1'b1;
        step();
        bus.DataOutReady = 1'b0;
        vectors++;
        if (bus.DataOutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_single got=%b exp=0", bus.DataOutValid);
        end
    endtask

    // Run the scenarios in order, then print the summary line.
    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset            = 1'b1;
        bus.DataIn       = 8'h00;
        bus.DataInValid  = 1'b0;
        bus.DataOutReady = 1'b0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_midop();
        test_empty_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
